mem_access: RTL

//  MEMORY stage plus MEM/WB pipeline register. Takes the EXECUTE result and control, runs the

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access_load_align.sv | 25 ++
 rtl/mem_access.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEMORY stage: control bit positions, access sizes, FSM states
// and the store-lane helpers used when MEM_SUBWORD_EN is defined.
package mem_access_pkg;

  localparam int M_READ_BIT    = 0;
  localparam int M_WRITE_BIT   = 1;
  localparam int WB_MEMSEL_BIT = 0;
  localparam int WB_REGWR_BIT  = 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // FUNCT3[1:0] carries the size; the unsigned variants share it with the signed ones.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEMORY stage (master) and the data memory (slave).
// dmem_req stays high with addr/we/wdata/be stable until the cycle dmem_ack=1 completes it;
// dmem_rdata is meaningful only in that ack cycle.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Load data alignment: shifts the addressed byte/half down to bit 0 and sign/zero extends.
// Only used when MEM_SUBWORD_EN is defined.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEMORY stage + MEM/WB register with dmem req/ack handshake and timeout watchdog.
// Optional sub-word loads/stores with misalign detection under `define MEM_SUBWORD_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // Upstream: an instruction transfers on a cycle where in_valid && in_ready.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  M_CTRL,
  input  logic [1:0]  WB_CTRL_IN,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic [4:0]  DEST_REG_IN,
  input  logic [2:0]  FUNCT3,
  mem_access_if.master dmem,
  output logic        out_valid,
  output logic [1:0]  WB_CTRL,
  output logic [31:0] ALU_OUT,
  output logic [31:0] MEM_OUT,
  output logic [4:0]  DEST_REG,
  output logic        bus_err,
  output state_t      dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [1:0]  pend_wb;
  logic [31:0] pend_alu;
  logic [4:0]  pend_dest;
  logic        pend_load;
  logic        accept, is_mem, misalign, acked, timed_out;
  logic [31:0] req_addr, req_wdata, load_word;
  logic [3:0]  req_be;

  assign in_ready  = (state == ST_IDLE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign is_mem    = (M_CTRL != 2'b00);

  always_comb begin
    req_addr  = {ALU_RESULT[31:2], 2'b00};
    req_be    = 4'hF;
    req_wdata = STORE_DATA;
    misalign  = 1'b0;
`ifdef MEM_SUBWORD_EN
    req_addr  = ALU_RESULT;
    req_be    = lane_be(FUNCT3, ALU_RESULT[1:0]);
    req_wdata = store_data(FUNCT3, STORE_DATA);
    misalign  = misaligned(FUNCT3, ALU_RESULT[1:0]);
`endif
  end

`ifdef MEM_SUBWORD_EN
  logic [2:0] pend_f3;

  always_ff @(posedge clk) begin
    if (!rst_n)                                pend_f3 <= 3'b000;
    else if (accept && is_mem && !misalign)    pend_f3 <= FUNCT3;
  end

  mem_access_load_align u_load_align (
    .addr   (dmem.dmem_addr[1:0]),
    .funct3 (pend_f3),
    .rdata  (dmem.dmem_rdata),
    .data   (load_word)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^FUNCT3;
  assign load_word     = dmem.dmem_rdata;
`endif

  // An ack in the same cycle the watchdog expires still completes the access.
  always_comb begin
    state_nxt = state;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      ST_IDLE: if (accept && is_mem && !misalign) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (dmem.dmem_ack) begin
          acked     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      WB_CTRL         <= 2'b00;
      ALU_OUT         <= 32'h0;
      MEM_OUT         <= 32'h0;
      DEST_REG        <= 5'd0;
      bus_err         <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_be    <= 4'h0;
      wait_cnt        <= 8'd0;
      pend_wb         <= 2'b00;
      pend_alu        <= 32'h0;
      pend_dest       <= 5'd0;
      pend_load       <= 1'b0;
    end else begin
      // Retire pulses last one cycle unless re-armed below.
      out_valid <= 1'b0;
      bus_err   <= 1'b0;
      WB_CTRL   <= 2'b00;
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 8'd1;

      if (accept && (!is_mem || misalign)) begin
        out_valid <= 1'b1;
        WB_CTRL   <= misalign ? 2'b00 : WB_CTRL_IN;
        ALU_OUT   <= ALU_RESULT;
        MEM_OUT   <= 32'h0;
        DEST_REG  <= DEST_REG_IN;
        bus_err   <= misalign;
      end else if (accept) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= M_CTRL[M_WRITE_BIT];
        dmem.dmem_addr  <= req_addr;
        dmem.dmem_wdata <= req_wdata;
        dmem.dmem_be    <= req_be;
        wait_cnt        <= 8'd0;
        pend_wb         <= WB_CTRL_IN;
        pend_alu        <= ALU_RESULT;
        pend_dest       <= DEST_REG_IN;
        pend_load       <= M_CTRL[M_READ_BIT] && !M_CTRL[M_WRITE_BIT];
      end

      if (acked || timed_out) begin
        dmem.dmem_req <= 1'b0;
        out_valid     <= 1'b1;
        WB_CTRL       <= acked ? pend_wb : 2'b00;
        ALU_OUT       <= pend_alu;
        MEM_OUT       <= (acked && pend_load) ? load_word : 32'h0;
        DEST_REG      <= pend_dest;
        bus_err       <= timed_out;
      end
    end
  end

endmodule
